// File: rtl/adc_capture_sched.sv
// adc_capture_sched: sequences ADC capture bursts into the sample buffer, gated on UDP availability.
// Build option: define ADC_CAPTURE_SCHED_CONT_EN to accept burst_len==0 as continuous capture.
module adc_capture_sched #(
  parameter int unsigned CNT_W          = 8,
  parameter int unsigned HOLDOFF_W      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 arm,
  input  logic                 abort,
  input  logic                 aligned,
  input  logic [CNT_W-1:0]     burst_len,
  input  logic [HOLDOFF_W-1:0] holdoff,
  input  logic                 buff_busy,
  input  logic                 udp_busy,
  output logic                 start_buff,
  output logic                 busy,
  output logic [CNT_W-1:0]     capture_cnt,
  output logic                 timeout_err,
  output logic                 done
);

  localparam int unsigned TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  // The START cycle is the first cycle of the ack window, so the timer holds the remainder.
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_RDY,
    START,
    WAIT_ACK,
    WAIT_DONE,
    HOLDOFF
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     len_q, len_d;
  logic [HOLDOFF_W-1:0] hold_q, hold_d;
  logic [HOLDOFF_W-1:0] hcnt_q, hcnt_d;
  logic [TMR_W-1:0]     tmr_q, tmr_d;
  logic                 cont_q, cont_d;
  logic [CNT_W-1:0]     cnt_d;
  logic                 terr_d;
  logic                 done_d;
  logic [CNT_W-1:0]     cnt_inc_c;
  logic                 arm_ok_c;
  logic                 cont_arm_c;

`ifdef ADC_CAPTURE_SCHED_CONT_EN
  assign arm_ok_c   = arm;
  assign cont_arm_c = (burst_len == '0);
`else
  assign arm_ok_c   = arm && (burst_len != '0);
  assign cont_arm_c = 1'b0;
`endif

  assign cnt_inc_c = capture_cnt + CNT_W'(1);

  // Next-state and register-next logic; abort overrides every transition out of a busy state.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    hold_d  = hold_q;
    hcnt_d  = hcnt_q;
    tmr_d   = tmr_q;
    cont_d  = cont_q;
    cnt_d   = capture_cnt;
    terr_d  = timeout_err;
    done_d  = 1'b0;

    if (state_q != IDLE && abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (arm_ok_c && !abort) begin
            len_d   = burst_len;
            hold_d  = holdoff;
            cont_d  = cont_arm_c;
            cnt_d   = '0;
            terr_d  = 1'b0;
            state_d = WAIT_RDY;
          end
        end
        WAIT_RDY: begin
          if (aligned && !buff_busy && !udp_busy) begin
            state_d = START;
          end
        end
        START: begin
          tmr_d   = TMR_LOAD;
          state_d = WAIT_ACK;
        end
        WAIT_ACK: begin
          if (buff_busy) begin
            state_d = WAIT_DONE;
          end else if (tmr_q <= TMR_W'(1)) begin
            tmr_d   = '0;
            terr_d  = 1'b1;
            state_d = IDLE;
          end else begin
            tmr_d = tmr_q - TMR_W'(1);
          end
        end
        WAIT_DONE: begin
          if (!buff_busy && !udp_busy) begin
            cnt_d = cnt_inc_c;
            if (!cont_q && cnt_inc_c == len_q) begin
              done_d  = 1'b1;
              state_d = IDLE;
            end else if (hold_q == '0) begin
              state_d = WAIT_RDY;
            end else begin
              hcnt_d  = hold_q;
              state_d = HOLDOFF;
            end
          end
        end
        HOLDOFF: begin
          if (hcnt_q <= HOLDOFF_W'(1)) begin
            hcnt_d  = '0;
            state_d = WAIT_RDY;
          end else begin
            hcnt_d = hcnt_q - HOLDOFF_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers; start_buff and busy are registered copies of the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      len_q       <= '0;
      hold_q      <= '0;
      hcnt_q      <= '0;
      tmr_q       <= '0;
      cont_q      <= 1'b0;
      start_buff  <= 1'b0;
      busy        <= 1'b0;
      capture_cnt <= '0;
      timeout_err <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      hold_q      <= hold_d;
      hcnt_q      <= hcnt_d;
      tmr_q       <= tmr_d;
      cont_q      <= cont_d;
      start_buff  <= (state_d == START);
      busy        <= (state_d != IDLE);
      capture_cnt <= cnt_d;
      timeout_err <= terr_d;
      done        <= done_d;
    end
  end

endmodule

// File: tb/tb_adc_capture_sched.sv
// tb_adc_capture_sched: randomized self-checking bench for adc_capture_sched.
// A buffer responder logs event cycles; each scenario derives expected cycles from the capture rules.
`timescale 1ns/1ps
module tb_adc_capture_sched;
  localparam int unsigned CNT_W          = 8;
  localparam int unsigned HOLDOFF_W      = 16;
  localparam int unsigned TIMEOUT_CYCLES = 1000;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 arm;
  logic                 abort;
  logic                 aligned;
  logic [CNT_W-1:0]     burst_len;
  logic [HOLDOFF_W-1:0] holdoff;
  logic                 buff_busy;
  logic                 udp_busy;
  logic                 start_buff;
  logic                 busy;
  logic [CNT_W-1:0]     capture_cnt;
  logic                 timeout_err;
  logic                 done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int start_q[$];
  int fall_q[$];
  int done_q[$];
  int terr_q[$];
  int cnt_q[$];
  bit buf_en  = 1'b1;
  int buf_dly = 2;
  int buf_len = 4;
  int bstate  = 0;
  int bcnt    = 0;
  logic             prev_terr = 1'b0;
  logic [CNT_W-1:0] prev_cnt  = '0;

  adc_capture_sched #(
    .CNT_W(CNT_W),
    .HOLDOFF_W(HOLDOFF_W),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk),
    .reset(reset),
    .arm(arm),
    .abort(abort),
    .aligned(aligned),
    .burst_len(burst_len),
    .holdoff(holdoff),
    .buff_busy(buff_busy),
    .udp_busy(udp_busy),
    .start_buff(start_buff),
    .busy(busy),
    .capture_cnt(capture_cnt),
    .timeout_err(timeout_err),
    .done(done)
  );

  always #4 clk = ~clk;

  // Buffer responder and event logger: busy D cycles after a start, for L cycles.
  initial begin
    buff_busy = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (bstate == 1) begin
        bcnt--;
        if (bcnt == 0) begin
          buff_busy = 1'b1;
          bstate    = 2;
          bcnt      = buf_len;
        end
      end else if (bstate == 2) begin
        bcnt--;
        if (bcnt == 0) begin
          buff_busy = 1'b0;
          bstate    = 0;
          fall_q.push_back(cyc);
        end
      end
      if (start_buff === 1'b1) begin
        start_q.push_back(cyc);
        if (buf_en && bstate == 0) begin
          bstate = 1;
          bcnt   = buf_dly;
        end
      end
      if (done === 1'b1) done_q.push_back(cyc);
      if (timeout_err === 1'b1 && prev_terr !== 1'b1) terr_q.push_back(cyc);
      prev_terr = timeout_err;
      if (reset === 1'b0 && capture_cnt === prev_cnt + CNT_W'(1)) cnt_q.push_back(int'(capture_cnt));
      prev_cnt = capture_cnt;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog sim_time got %0t required_below 2000000", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_log();
    start_q.delete();
    fall_q.delete();
    done_q.delete();
    terr_q.delete();
    cnt_q.delete();
  endtask

  task automatic arm_burst(input int unsigned len, input int unsigned hold, output int arm_cyc);
    burst_len = CNT_W'(len);
    holdoff   = HOLDOFF_W'(hold);
    arm       = 1'b1;
    arm_cyc   = cyc;
    tick();
    arm = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n;
    n = 0;
    while (busy === 1'b1 && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle busy got %b required 0 after %0d cycles", tag, busy, n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; arm = 1'b1; burst_len = CNT_W'(3); holdoff = '0;
    repeat (5) tick();
    checks++; if (start_buff !== 1'b0) begin errors++; $display("FAIL reset_start got %b required 0", start_buff); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b required 0", busy); end
    checks++; if (capture_cnt !== '0) begin errors++; $display("FAIL reset_cnt got %0d required 0", capture_cnt); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_terr got %b required 0", timeout_err); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b required 0", done); end
    reset = 1'b0; arm = 1'b0;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_arm_leak busy got %b required 0", busy); end
  endtask

  task automatic test_basic_burst();
    for (int it = 0; it < 4; it++) begin
      int a;
      int unsigned len;
      int unsigned hold;
      if (it == 0) begin
        len = 3; hold = 10; buf_dly = 2; buf_len = 50;
      end else begin
        len = $urandom_range(1, 4); hold = $urandom_range(0, 12);
        buf_dly = int'($urandom_range(1, 3)); buf_len = int'($urandom_range(1, 20));
      end
      buf_en = 1'b1;
      clear_log();
      arm_burst(len, hold, a);
      wait_idle(1000, "basic");
      checks++; if (start_q.size() != int'(len)) begin errors++; $display("FAIL basic_starts got %0d required %0d", start_q.size(), len); end
      checks++; if (done_q.size() != 1) begin errors++; $display("FAIL basic_done got %0d required 1", done_q.size()); end
      checks++; if (capture_cnt !== CNT_W'(len)) begin errors++; $display("FAIL basic_cnt got %0d required %0d", capture_cnt, len); end
      if (start_q.size() > 0) begin
        checks++; if (start_q[0] != a + 2) begin errors++; $display("FAIL basic_first_start got %0d required %0d", start_q[0], a + 2); end
      end
      for (int i = 0; i < cnt_q.size(); i++) begin
        checks++; if (cnt_q[i] != i + 1) begin errors++; $display("FAIL basic_cnt_seq[%0d] got %0d required %0d", i, cnt_q[i], i + 1); end
      end
      for (int i = 1; i < int'(len); i++) begin
        if (start_q.size() > i && fall_q.size() >= i) begin
          checks++;
          if (start_q[i] != fall_q[i-1] + int'(hold) + 2) begin
            errors++; $display("FAIL basic_gap[%0d] got %0d required %0d", i, start_q[i], fall_q[i-1] + int'(hold) + 2);
          end
        end
      end
      if (done_q.size() > 0 && fall_q.size() == int'(len)) begin
        checks++; if (done_q[0] != fall_q[len-1] + 1) begin errors++; $display("FAIL basic_done_time got %0d required %0d", done_q[0], fall_q[len-1] + 1); end
      end
      repeat (3) tick();
    end
  endtask

  task automatic test_min_gap();
    int a;
    buf_en = 1'b1; buf_dly = 1; buf_len = 1;
    clear_log();
    arm_burst(6, 0, a);
    wait_idle(200, "min_gap");
    checks++; if (start_q.size() != 6) begin errors++; $display("FAIL min_gap_starts got %0d required 6", start_q.size()); end
    for (int i = 1; i < start_q.size(); i++) begin
      checks++; if (start_q[i] - start_q[i-1] != 4) begin errors++; $display("FAIL min_gap[%0d] got %0d required 4", i, start_q[i] - start_q[i-1]); end
    end
    tick();
  endtask

  task automatic test_align_gating();
    int a;
    int al;
    int n;
    aligned = 1'b0; buf_en = 1'b1; buf_dly = 2; buf_len = 5;
    clear_log();
    arm_burst(1, 0, a);
    repeat (100) tick();
    checks++; if (start_q.size() != 0) begin errors++; $display("FAIL align_no_start got %0d required 0", start_q.size()); end
    checks++; if (busy !== 1'b1 || timeout_err !== 1'b0) begin errors++; $display("FAIL align_waiting busy/terr got %b%b required 10", busy, timeout_err); end
    aligned = 1'b1;
    al = cyc;
    n = 0;
    while (start_q.size() == 0 && n < 10) begin tick(); n++; end
    checks++;
    if (start_q.size() != 1 || start_q[0] - al < 1 || start_q[0] - al > 2) begin
      errors++; $display("FAIL align_start_latency got %0d starts (first at +%0d) required 1 start at +1..+2", start_q.size(), (start_q.size() > 0) ? start_q[0] - al : -1);
    end
    wait_idle(200, "align");
    checks++; if (done_q.size() != 1) begin errors++; $display("FAIL align_done got %0d required 1", done_q.size()); end
  endtask

  task automatic test_timeout();
    int a;
    buf_en = 1'b0;
    clear_log();
    arm_burst(1, 0, a);
    wait_idle(1200, "timeout");
    checks++; if (terr_q.size() != 1) begin errors++; $display("FAIL timeout_rise got %0d required 1", terr_q.size()); end
    if (terr_q.size() > 0 && start_q.size() > 0) begin
      checks++;
      if (terr_q[0] - start_q[0] != int'(TIMEOUT_CYCLES)) begin
        errors++; $display("FAIL timeout_latency got %0d required %0d", terr_q[0] - start_q[0], TIMEOUT_CYCLES);
      end
    end
    checks++; if (done_q.size() != 0) begin errors++; $display("FAIL timeout_no_done got %0d required 0", done_q.size()); end
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL timeout_sticky got %b required 1", timeout_err); end
    buf_en = 1'b1; buf_dly = 2; buf_len = 3;
    clear_log();
    arm_burst(1, 0, a);
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL timeout_clear got %b required 0", timeout_err); end
    wait_idle(200, "timeout_rearm");
    checks++; if (done_q.size() != 1) begin errors++; $display("FAIL timeout_rearm_done got %0d required 1", done_q.size()); end
  endtask

  task automatic test_abort();
    int a;
    int n;
    buf_en = 1'b1; buf_dly = 1; buf_len = 3;
    clear_log();
    arm_burst(5, 30, a);
    n = 0;
    while (cnt_q.size() < 2 && n < 200) begin tick(); n++; end
    checks++; if (cnt_q.size() != 2) begin errors++; $display("FAIL abort_reach_cap2 got %0d required 2", cnt_q.size()); end
    repeat (5) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_idle busy got %b required 0", busy); end
    checks++; if (capture_cnt !== CNT_W'(2)) begin errors++; $display("FAIL abort_cnt got %0d required 2", capture_cnt); end
    repeat (60) tick();
    checks++; if (start_q.size() != 2) begin errors++; $display("FAIL abort_starts got %0d required 2", start_q.size()); end
    checks++; if (done_q.size() != 0) begin errors++; $display("FAIL abort_done got %0d required 0", done_q.size()); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL abort_terr got %b required 0", timeout_err); end
    abort = 1'b1; arm = 1'b1; burst_len = CNT_W'(4);
    tick();
    arm = 1'b0; abort = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_beats_arm busy got %b required 0", busy); end
    tick();
  endtask

  task automatic test_udp_backpressure();
    for (int it = 0; it < 2; it++) begin
      int a;
      int n;
      int fall1;
      int u_off;
      int exp_start;
      int unsigned hold;
      if (it == 0) hold = $urandom_range(0, 150);
      else hold = $urandom_range(210, 300);
      buf_en = 1'b1; buf_dly = 2; buf_len = 4;
      clear_log();
      arm_burst(2, hold, a);
      n = 0;
      while (cnt_q.size() < 1 && n < 200) begin tick(); n++; end
      checks++; if (cnt_q.size() != 1) begin errors++; $display("FAIL udp_cap1 got %0d required 1", cnt_q.size()); end
      udp_busy = 1'b1;
      fall1 = (fall_q.size() > 0) ? fall_q[0] : 0;
      for (int k = 0; k < 200; k++) begin
        if (k == 50 || k == 120) begin
          burst_len = CNT_W'(9);
          arm = 1'b1;
        end else begin
          arm = 1'b0;
        end
        tick();
      end
      arm = 1'b0;
      udp_busy = 1'b0;
      u_off = cyc;
      exp_start = (u_off + 1 > fall1 + int'(hold) + 2) ? u_off + 1 : fall1 + int'(hold) + 2;
      wait_idle(600, "udp");
      checks++; if (start_q.size() != 2) begin errors++; $display("FAIL udp_starts got %0d required 2", start_q.size()); end
      if (start_q.size() > 1) begin
        checks++; if (start_q[1] != exp_start) begin errors++; $display("FAIL udp_start2 got %0d required %0d", start_q[1], exp_start); end
      end
      checks++; if (done_q.size() != 1) begin errors++; $display("FAIL udp_done got %0d required 1", done_q.size()); end
      checks++; if (capture_cnt !== CNT_W'(2)) begin errors++; $display("FAIL udp_cnt got %0d required 2", capture_cnt); end
      tick();
    end
  endtask

`ifdef ADC_CAPTURE_SCHED_CONT_EN
  task automatic test_continuous();
    int a;
    int n;
    int bad;
    buf_en = 1'b1; buf_dly = 1; buf_len = 1;
    clear_log();
    arm_burst(0, 0, a);
    n = 0;
    while (cnt_q.size() < 300 && n < 1500) begin tick(); n++; end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cont_abort busy got %b required 0", busy); end
    checks++; if (cnt_q.size() < 300) begin errors++; $display("FAIL cont_captures got %0d required >=300", cnt_q.size()); end
    bad = 0;
    for (int i = 0; i < cnt_q.size(); i++) if (cnt_q[i] != (i + 1) % 256) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL cont_cnt_seq got %0d bad entries required 0", bad); end
    if (cnt_q.size() > 255) begin
      checks++; if (cnt_q[255] != 0) begin errors++; $display("FAIL cont_wrap got %0d required 0", cnt_q[255]); end
    end
    checks++; if (done_q.size() != 0) begin errors++; $display("FAIL cont_done got %0d required 0", done_q.size()); end
  endtask
`else
  task automatic test_zero_len();
    int a;
    clear_log();
    arm_burst(0, 5, a);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_len_busy got %b required 0", busy); end
    repeat (5) tick();
    checks++; if (start_q.size() != 0) begin errors++; $display("FAIL zero_len_starts got %0d required 0", start_q.size()); end
  endtask
`endif

  initial begin
    reset = 1'b1; arm = 1'b0; abort = 1'b0; aligned = 1'b1; udp_busy = 1'b0;
    burst_len = '0; holdoff = '0;
    test_reset();
    test_basic_burst();
    test_min_gap();
    test_align_gating();
    test_timeout();
    test_abort();
    test_udp_backpressure();
`ifdef ADC_CAPTURE_SCHED_CONT_EN
    test_continuous();
`else
    test_zero_len();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
